// File: rtl/AHB_package.sv
// Shared AHB transfer/response types plus the decoder's default-slave state encoding.
// Pure declarations: no latency, no backpressure.
package AHB_package;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_type;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } dflt_state_e;

    localparam int AHB_MAX_SLAVE_NUM = 16;

    function automatic logic is_active(input htrans_type t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped space: zero-wait OKAY for IDLE/BUSY, two-cycle ERROR for NONSEQ/SEQ.
// Latency: ERROR appears 1 and 2 cycles after the accepted address phase; inserts one wait state per error.
module ahb_default_slave
    import AHB_package::*;
(
    input  logic       hclk,
    input  logic       hreset_n,
    input  logic       sel,
    input  htrans_type htrans,
    input  logic       hready,
    output logic       hreadyout,
    output hresp_type  hresp
);

    dflt_state_e state_q, state_d;
    logic        start;

    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = OKAY;
        start     = sel && hready && is_active(htrans);
        case (state_q)
            DS_IDLE: begin
                if (start) state_d = DS_ERR1;
            end
            DS_ERR1: begin
                hreadyout = 1'b0;
                hresp     = ERROR;
                state_d   = DS_ERR2;
            end
            DS_ERR2: begin
                // Second ERROR cycle doubles as the next address phase.
                hresp   = ERROR;
                state_d = start ? DS_ERR1 : DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) state_q <= DS_IDLE;
        else           state_q <= state_d;
    end

endmodule

// File: rtl/ahb_decoder_mux_gen.sv
// AHB address decoder + response mux for one master; optional boot alias under AHB_DECODER_REMAP_EN.
// Latency: hsel comb, data_sel 1 cycle; backpressure: all state holds while the bus hready is low.
module ahb_decoder_mux_gen
    import AHB_package::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int SLAVE_NUM      = 4,
    parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] LOW_ADDR =
        {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
    parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] HIGH_ADDR =
        {32'h4FFF_FFFF, 32'h3FFF_FFFF, 32'h2FFF_FFFF, 32'h1FFF_FFFF}
) (
    input  logic                       hclk,
    input  logic                       hreset_n,
    input  logic [AHB_ADDR_WIDTH-1:0]  haddr,
    input  htrans_type                 htrans,
    output logic                       hready,
    output hresp_type                  hresp,
    output logic [SLAVE_NUM-1:0]       hsel,
    output logic                       default_slv_sel,
    output logic [SLAVE_NUM:0]         data_sel,
    input  logic [SLAVE_NUM-1:0]       hreadyout_s,
    input  logic [SLAVE_NUM-1:0][1:0]  hresp_s,
    input  logic                       hremap
);

    if (SLAVE_NUM < 1 || SLAVE_NUM > AHB_MAX_SLAVE_NUM) begin : g_bad_cfg
        $error("ahb_decoder_mux_gen: SLAVE_NUM out of range");
    end

    logic [SLAVE_NUM-1:0] slave_detect;
    logic [SLAVE_NUM:0]   data_sel_q, data_sel_d;
    logic                 act_q, act_d;
    logic                 dflt_hreadyout;
    hresp_type            dflt_hresp;

`ifdef AHB_DECODER_REMAP_EN
    localparam int REMAP_IDX = (SLAVE_NUM > 1) ? 1 : 0;
`else
    logic remap_unused;
    assign remap_unused = hremap;
`endif

    always_comb begin
        slave_detect = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            slave_detect[i] = (haddr >= LOW_ADDR[i]) && (haddr <= HIGH_ADDR[i]);
        end
`ifdef AHB_DECODER_REMAP_EN
        // Boot alias: a window the size of slave 0's region at address 0 goes to slave 1.
        if (hremap && (haddr <= (HIGH_ADDR[0] - LOW_ADDR[0]))) begin
            slave_detect            = '0;
            slave_detect[REMAP_IDX] = 1'b1;
        end
`endif
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hsel = '0;
        for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
            if (slave_detect[i]) begin
                hsel    = '0;
                hsel[i] = 1'b1;
            end
        end
    end

    assign default_slv_sel = ~|slave_detect;

    always_comb begin
        data_sel_d = data_sel_q;
        act_d      = act_q;
        if (hready) begin
            data_sel_d = {default_slv_sel, hsel};
            act_d      = is_active(htrans);
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            data_sel_q <= {1'b1, {SLAVE_NUM{1'b0}}};
            act_q      <= 1'b0;
        end else begin
            data_sel_q <= data_sel_d;
            act_q      <= act_d;
        end
    end

    assign data_sel = data_sel_q;

    ahb_default_slave u_default_slave (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .sel       (default_slv_sel),
        .htrans    (htrans),
        .hready    (hready),
        .hreadyout (dflt_hreadyout),
        .hresp     (dflt_hresp)
    );

    always_comb begin
        hready = dflt_hreadyout;
        hresp  = dflt_hresp;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (data_sel_q[i]) begin
                hready = hreadyout_s[i];
                hresp  = hresp_type'(hresp_s[i]);
            end
        end
    end

    // A default-slave data phase with no active transfer behind it must be a plain OKAY.
    idle_dflt_okay: assert property (@(posedge hclk) disable iff (!hreset_n)
        (data_sel_q[SLAVE_NUM] && !act_q) |-> (hready && hresp == OKAY));

endmodule

// File: tb/tb_ahb_decoder_mux_gen.sv
// Bench for ahb_decoder_mux_gen: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ahb_decoder_mux_gen;
    import AHB_package::*;

    localparam int N = 2;
`ifdef AHB_DECODER_REMAP_EN
    localparam bit REMAP_EN = 1'b1;
`else
    localparam bit REMAP_EN = 1'b0;
`endif

    logic              hclk = 1'b0;
    logic              hreset_n;
    logic [31:0]       haddr;
    htrans_type        htrans;
    logic              hready;
    hresp_type         hresp;
    logic [N-1:0]      hsel;
    logic              default_slv_sel;
    logic [N:0]        data_sel;
    logic [N-1:0]      hreadyout_s;
    logic [N-1:0][1:0] hresp_s;
    logic              hremap;

    int checks = 0;
    int errors = 0;

    logic [31:0] lo_tab [N] = '{32'h400, 32'h800};
    logic [31:0] hi_tab [N] = '{32'h7FF, 32'hFFF};

    ahb_decoder_mux_gen #(
        .AHB_ADDR_WIDTH (32),
        .SLAVE_NUM      (N),
        .LOW_ADDR       ({32'h800, 32'h400}),
        .HIGH_ADDR      ({32'hFFF, 32'h7FF})
    ) dut (
        .hclk            (hclk),
        .hreset_n        (hreset_n),
        .haddr           (haddr),
        .htrans          (htrans),
        .hready          (hready),
        .hresp           (hresp),
        .hsel            (hsel),
        .default_slv_sel (default_slv_sel),
        .data_sel        (data_sel),
        .hreadyout_s     (hreadyout_s),
        .hresp_s         (hresp_s),
        .hremap          (hremap)
    );

    always #5 hclk = ~hclk;

    // Owner of an address: index of the lowest matching region, N for unmapped.
    function automatic int model_decode(input logic [31:0] a, input logic rm);
        if (REMAP_EN && rm && (a <= hi_tab[0] - lo_tab[0])) return 1;
        for (int i = 0; i < N; i++) begin
            if (a >= lo_tab[i] && a <= hi_tab[i]) return i;
        end
        return N;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h3FF;
            1:       return 32'h400;
            2:       return 32'h7FF;
            3:       return 32'h800;
            4:       return 32'hFFF;
            5:       return 32'h1000;
            6:       return 32'h0;
            7:       return 32'h10;
            8:       return 32'h2000;
            default: return {16'h0, 16'($urandom)};
        endcase
    endfunction

    task automatic test_reset();
        hreset_n    = 1'b0;
        haddr       = 32'h0;
        htrans      = IDLE;
        hreadyout_s = '1;
        hresp_s     = '0;
        hremap      = 1'b0;
        repeat (2) @(negedge hclk);
        #1;
        checks++; if (hready !== 1'b1) begin errors++; $display("FAIL reset_hready got %b want 1", hready); end
        checks++; if (hresp !== OKAY) begin errors++; $display("FAIL reset_hresp got %0d want 0", hresp); end
        checks++; if (data_sel !== 3'b100) begin errors++; $display("FAIL reset_data_sel got %b want 100", data_sel); end
        @(negedge hclk);
        hreset_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] ba [4] = '{32'h3FF, 32'h800, 32'hFFF, 32'h1000};
        logic [1:0]  bh [4] = '{2'b00, 2'b10, 2'b10, 2'b00};
        for (int k = 0; k < 2; k++) begin
            @(negedge hclk);
            haddr  = (k == 0) ? 32'h400 : 32'h7FF;
            htrans = NONSEQ;
            #1;
            checks++; if (hsel !== 2'b01) begin errors++; $display("FAIL decode_hsel addr %h got %b want 01", haddr, hsel); end
            checks++; if (default_slv_sel !== 1'b0) begin errors++; $display("FAIL decode_dflt addr %h got %b want 0", haddr, default_slv_sel); end
            @(negedge hclk);
            #1;
            checks++; if (data_sel !== 3'b001) begin errors++; $display("FAIL decode_data_sel addr %h got %b want 001", haddr, data_sel); end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge hclk);
            haddr  = ba[k];
            htrans = IDLE;
            #1;
            checks++; if (hsel !== bh[k]) begin errors++; $display("FAIL bound_hsel addr %h got %b want %b", haddr, hsel, bh[k]); end
            checks++; if (default_slv_sel !== (bh[k] == 2'b00)) begin errors++; $display("FAIL bound_dflt addr %h got %b want %b", haddr, default_slv_sel, bh[k] == 2'b00); end
        end
    endtask

    task automatic test_error();
        @(negedge hclk);
        haddr  = 32'h2000;
        htrans = NONSEQ;
        #1;
        checks++; if (default_slv_sel !== 1'b1) begin errors++; $display("FAIL err_dflt got %b want 1", default_slv_sel); end
        @(negedge hclk);
        htrans = IDLE;
        #1;
        checks++; if (hready !== 1'b0 || hresp !== ERROR) begin errors++; $display("FAIL err_cycle1 got rdy %b resp %0d want rdy 0 resp 1", hready, hresp); end
        checks++; if (data_sel !== 3'b100) begin errors++; $display("FAIL err_data_sel got %b want 100", data_sel); end
        @(negedge hclk);
        #1;
        checks++; if (hready !== 1'b1 || hresp !== ERROR) begin errors++; $display("FAIL err_cycle2 got rdy %b resp %0d want rdy 1 resp 1", hready, hresp); end
        @(negedge hclk);
        #1;
        checks++; if (hready !== 1'b1 || hresp !== OKAY) begin errors++; $display("FAIL err_after got rdy %b resp %0d want rdy 1 resp 0", hready, hresp); end
    endtask

    task automatic test_idle_busy();
        htrans_type seq_t [4] = '{IDLE, BUSY, IDLE, IDLE};
        for (int k = 0; k < 4; k++) begin
            @(negedge hclk);
            haddr  = 32'h2000;
            htrans = seq_t[k];
            #1;
            checks++; if (hready !== 1'b1 || hresp !== OKAY) begin errors++; $display("FAIL idle_busy step %0d got rdy %b resp %0d want rdy 1 resp 0", k, hready, hresp); end
        end
    endtask

    task automatic test_wait_states();
        @(negedge hclk);
        haddr       = 32'h800;
        htrans      = NONSEQ;
        hreadyout_s = 2'b11;
        hresp_s     = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge hclk);
            haddr       = 32'h400;
            hreadyout_s = 2'b01;
            #1;
            checks++; if (data_sel !== 3'b010) begin errors++; $display("FAIL wait_data_sel cyc %0d got %b want 010", k, data_sel); end
            checks++; if (hready !== 1'b0) begin errors++; $display("FAIL wait_hready cyc %0d got %b want 0", k, hready); end
        end
        @(negedge hclk);
        hreadyout_s = 2'b11;
        #1;
        checks++; if (hready !== 1'b1 || data_sel !== 3'b010) begin errors++; $display("FAIL wait_release got rdy %b sel %b want rdy 1 sel 010", hready, data_sel); end
        @(negedge hclk);
        #1;
        checks++; if (data_sel !== 3'b001) begin errors++; $display("FAIL wait_switch got %b want 001", data_sel); end
    endtask

    task automatic test_back_to_back();
        @(negedge hclk);
        haddr  = 32'h2000;
        htrans = NONSEQ;
        #1;
        checks++; if (hready !== 1'b1) begin errors++; $display("FAIL b2b_start got rdy %b want 1", hready); end
        @(negedge hclk);
        haddr  = 32'h3000;
        htrans = SEQ;
        #1;
        checks++; if (hready !== 1'b0 || hresp !== ERROR) begin errors++; $display("FAIL b2b_err1 got rdy %b resp %0d want rdy 0 resp 1", hready, hresp); end
        @(negedge hclk);
        #1;
        checks++; if (hready !== 1'b1 || hresp !== ERROR) begin errors++; $display("FAIL b2b_err2 got rdy %b resp %0d want rdy 1 resp 1", hready, hresp); end
        @(negedge hclk);
        #1;
        checks++; if (hready !== 1'b0 || hresp !== ERROR) begin errors++; $display("FAIL b2b_reenter got rdy %b resp %0d want rdy 0 resp 1", hready, hresp); end
        #1;
        hreset_n = 1'b0;
        #1;
        checks++; if (hready !== 1'b1 || hresp !== OKAY || data_sel !== 3'b100) begin
            errors++; $display("FAIL b2b_reset got rdy %b resp %0d sel %b want rdy 1 resp 0 sel 100", hready, hresp, data_sel);
        end
        @(negedge hclk);
        htrans   = IDLE;
        hreset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge hclk);
            #1;
            checks++; if (hready !== 1'b1 || hresp !== OKAY) begin errors++; $display("FAIL b2b_post_reset cyc %0d got rdy %b resp %0d want rdy 1 resp 0", k, hready, hresp); end
        end
    endtask

    task automatic test_remap();
        @(negedge hclk);
        hreadyout_s = 2'b11;
        hremap      = 1'b1;
        haddr       = 32'h10;
        htrans      = NONSEQ;
        #1;
`ifdef AHB_DECODER_REMAP_EN
        checks++; if (hsel !== 2'b10 || default_slv_sel !== 1'b0) begin errors++; $display("FAIL remap_on got hsel %b dflt %b want 10 0", hsel, default_slv_sel); end
        @(negedge hclk);
        hremap = 1'b0;
        #1;
        checks++; if (data_sel !== 3'b010 || hready !== 1'b1) begin errors++; $display("FAIL remap_dphase got sel %b rdy %b want 010 1", data_sel, hready); end
        checks++; if (hsel !== 2'b00 || default_slv_sel !== 1'b1) begin errors++; $display("FAIL remap_off got hsel %b dflt %b want 00 1", hsel, default_slv_sel); end
`else
        checks++; if (hsel !== 2'b00 || default_slv_sel !== 1'b1) begin errors++; $display("FAIL remap_ignored got hsel %b dflt %b want 00 1", hsel, default_slv_sel); end
`endif
        @(negedge hclk);
        hremap = 1'b0;
        htrans = IDLE;
        #1;
        checks++; if (hready !== 1'b0 || hresp !== ERROR) begin errors++; $display("FAIL remap_err1 got rdy %b resp %0d want 0 1", hready, hresp); end
        @(negedge hclk);
        #1;
        checks++; if (hready !== 1'b1 || hresp !== ERROR) begin errors++; $display("FAIL remap_err2 got rdy %b resp %0d want 1 1", hready, hresp); end
        @(negedge hclk);
        #1;
        checks++; if (hready !== 1'b1 || hresp !== OKAY) begin errors++; $display("FAIL remap_okay got rdy %b resp %0d want 1 0", hready, hresp); end
    endtask

    task automatic test_random();
        int           m_owner;
        int           m_err;
        int           dec;
        logic [N-1:0] exp_hsel;
        logic [N:0]   exp_dsel;
        logic         exp_rdy;
        logic [1:0]   exp_resp;
        @(negedge hclk);
        hreset_n = 1'b0;
        htrans   = IDLE;
        @(negedge hclk);
        hreset_n = 1'b1;
        m_owner  = N;
        m_err    = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge hclk);
            haddr  = pick_addr();
            htrans = htrans_type'($urandom_range(0, 3));
            hremap = 1'($urandom_range(0, 1));
            for (int b = 0; b < N; b++) begin
                hreadyout_s[b] = ($urandom_range(0, 3) != 0);
                hresp_s[b]     = 2'($urandom_range(0, 1));
            end
            #1;
            dec      = model_decode(haddr, hremap);
            exp_hsel = '0;
            if (dec < N) exp_hsel[dec] = 1'b1;
            exp_dsel = '0;
            exp_dsel[m_owner] = 1'b1;
            if (m_owner < N) begin
                exp_rdy  = hreadyout_s[m_owner];
                exp_resp = hresp_s[m_owner];
            end else begin
                exp_rdy  = (m_err != 2);
                exp_resp = (m_err != 0) ? 2'b01 : 2'b00;
            end
            checks++; if (hsel !== exp_hsel) begin errors++; $display("FAIL rnd_hsel cyc %0d addr %h got %b want %b", c, haddr, hsel, exp_hsel); end
            checks++; if (default_slv_sel !== (dec == N)) begin errors++; $display("FAIL rnd_dflt cyc %0d addr %h got %b want %b", c, haddr, default_slv_sel, dec == N); end
            checks++; if (data_sel !== exp_dsel) begin errors++; $display("FAIL rnd_data_sel cyc %0d got %b want %b", c, data_sel, exp_dsel); end
            checks++; if (hready !== exp_rdy) begin errors++; $display("FAIL rnd_hready cyc %0d got %b want %b", c, hready, exp_rdy); end
            checks++; if (hresp !== exp_resp) begin errors++; $display("FAIL rnd_hresp cyc %0d got %0d want %0d", c, hresp, exp_resp); end
            @(posedge hclk);
            if (exp_rdy) begin
                m_owner = dec;
                m_err   = (dec == N && (htrans == NONSEQ || htrans == SEQ)) ? 2 : 0;
            end else if (m_err == 2) begin
                m_err = 1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_error();
        test_idle_busy();
        test_wait_states();
        test_back_to_back();
        test_remap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
